yuv422_unpacker: RTL and testbench
==================================

Name: yuv422_unpacker

Overview:
- Upstream neighbour of the Y'UV-to-RGB converter. Accepts the camera's packed 4:2:2 byte stream (one byte per accepted cycle) and rebuilds full 4:4:4 pixels.
- Each pixel is presented as 24-bit {Y[23:16], U[15:8], V[7:0]}, which is the converter's input format.
- Also tracks column position, flags line ends and detects malformed lines.
- No backpressure: the camera cannot stall, so downstream must accept one pixel per cycle.

Parameters:
- LINE_WIDTH, 640, pixels per line (even, ≥2).
- BYTE_ORDER, 0, 0 = Y0 U Y1 V (YUYV); 1 = U Y0 V Y1 (UYVY).
- CW, $clog2(LINE_WIDTH), column counter width (derived, not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vsync  in  1  frame sync, level; high = inter-frame blanking
- href  in  1  line valid, level; bytes are accepted only while high
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  packed 4:2:2 byte
- yuv_data  out  24  {Y,U,V} pixel
- yuv_valid  out  1  single-cycle pixel strobe
- pixel_col  out  CW  column of the current yuv_data, 0..LINE_WIDTH-1
- line_end  out  1  high with the pixel at column LINE_WIDTH-1
- frag_err  out  1  sticky malformed-line flag

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (reset). Everything updates on the rising edge of clk.
- Reset values: yuv_data=0, yuv_valid=0, pixel_col=0, line_end=0, frag_err=0; phase FSM=PH0; pending flag=0; column counter=0.
- Byte acceptance: a byte is accepted when byte_valid && href && !vsync.
- Phase FSM: PH0→PH1→PH2→PH3→PH0, advancing only on an accepted byte.
  - BYTE_ORDER=0: PH0 captures Y0, PH1 U, PH2 Y1, PH3 V.
  - BYTE_ORDER=1: PH0 captures U, PH1 Y0, PH2 V, PH3 Y1.
- Pixel emission: on the edge that accepts the PH3 byte, the registered outputs present pixel0={Y0,U,V} with yuv_valid=1.
  - On the next edge, pixel1={Y1,U,V} is presented from the one-entry pending register, with yuv_valid=1.
  - Latency from the last group byte: pixel0 in 1 cycle, pixel1 in 2 cycles.
  - The next group completes ≥4 cycles later, so emissions never collide.
- pixel_col: equals the internal column counter at emission time; the counter increments after each emitted pixel.
  - line_end = yuv_valid && (pixel_col == LINE_WIDTH-1).
- Line close: on an href falling edge (href registered high, now low):
  - If FSM != PH0, set frag_err, drop the partial group and force PH0.
  - If the count of emitted pixels plus pending pixels != LINE_WIDTH, set frag_err.
  - The column counter clears after any pending pixel has been emitted.
- Overrun: bytes that would produce a pixel beyond column LINE_WIDTH-1 complete groups normally, but no pixels are emitted. frag_err is set and the column counter saturates.
- vsync high: FSM→PH0, column counter→0, pending pixel dropped, yuv_valid forced 0. frag_err is unaffected.
- Reset mid-line: all state returns to reset values on the next edge; the partial group is discarded.
- Simultaneous events: if vsync rises on the same edge that completes a group, vsync wins and no pixel is emitted.
- frag_err is cleared only by reset.
- Chroma is passed through unmodified as unsigned 8-bit values; there is no offset or interpolation.

Optional Feature:
- Macro: YUV422_ROW_COUNT_EN.
- When defined:
  - Adds output pixel_row, width $clog2(1024)=10. It increments at each href falling edge that closes a line and clears when vsync is high or on reset.
  - Adds output frame_end, a one-cycle pulse on a vsync rising edge when pixel_row != 0.
- When undefined: neither port exists; the rest of the behaviour is identical.

Test Plan:
- LINE_WIDTH=4, BYTE_ORDER=0, bytes 10,80,20,90,30,70,40,60 back-to-back with href high → pixels {10,80,90}@col0, {20,80,90}@col1, {30,70,60}@col2, {40,70,60}@col3; yuv_valid 1 and 2 cycles after each V byte; line_end only with col3; frag_err=0.
- BYTE_ORDER=1, bytes 80,10,90,20 with byte_valid toggling 1,0,1,0,… → {10,80,90} then {20,80,90}; column increments only on emission.
- href falls after 6 bytes of a 4-pixel line → pixels col0/col1 emitted, partial group dropped, frag_err=1 and stays 1 across the next good line; FSM restarts at PH0 (next line decodes correctly).
- 12 bytes in a LINE_WIDTH=4 line → 4 pixels emitted, no pixel for the extra group, frag_err=1.
- reset asserted after PH2 byte → next cycle all outputs 0; a new line then decodes correctly from byte 0. vsync pulse mid-group → no emission, col restarts at 0.
- YUV422_ROW_COUNT_EN defined, 3 lines then vsync rise → pixel_row 0,1,2,3 at line closes; frame_end pulses once; pixel_row=0 afterwards.

Source files
------------

// File: rtl/yuv422_unpacker.sv
// Packed 4:2:2 byte stream to 24-bit {Y,U,V} pixels with column tracking.
// Define YUV422_ROW_COUNT_EN to add the pixel_row and frame_end outputs.
module yuv422_unpacker #(
    parameter int LINE_WIDTH = 640,
    parameter int BYTE_ORDER = 0,
    localparam int CW = $clog2(LINE_WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vsync,
    input  logic          href,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic [23:0]   yuv_data,
    output logic          yuv_valid,
    output logic [CW-1:0] pixel_col,
    output logic          line_end,
    output logic          frag_err
`ifdef YUV422_ROW_COUNT_EN
    ,
    output logic [9:0]    pixel_row,
    output logic          frame_end
`endif
);

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    localparam logic [CW:0] LW = LINE_WIDTH[CW:0];

    phase_t      phase, phase_next;
    logic        accept, line_close, group_done, room;
    logic        href_q, pend;
    logic [7:0]  b0, b1, b2;
    logic [7:0]  y0, y1, u, v;
    logic [23:0] pend_data;
    logic [CW:0] cnt;

    assign accept     = byte_valid && href && !vsync;
    assign line_close = href_q && !href && !vsync;
    assign group_done = accept && (phase == PH3);
    assign room       = cnt < LW;

    // The fourth byte of a group is used straight from the input.
    always_comb begin
        if (BYTE_ORDER == 0) begin
            y0 = b0;
            u  = b1;
            y1 = b2;
            v  = byte_data;
        end else begin
            u  = b0;
            y0 = b1;
            v  = b2;
            y1 = byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) phase <= PH0;
        else       phase <= phase_next;
    end

    always_comb begin
        phase_next = phase;
        if (vsync || line_close) begin
            phase_next = PH0;
        end else if (accept) begin
            unique case (phase)
                PH0: phase_next = PH1;
                PH1: phase_next = PH2;
                PH2: phase_next = PH3;
                PH3: phase_next = PH0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            href_q    <= 1'b0;
            pend      <= 1'b0;
            pend_data <= '0;
            b0        <= '0;
            b1        <= '0;
            b2        <= '0;
            cnt       <= '0;
            yuv_data  <= '0;
            yuv_valid <= 1'b0;
            pixel_col <= '0;
            line_end  <= 1'b0;
            frag_err  <= 1'b0;
        end else begin
            href_q    <= href;
            yuv_valid <= 1'b0;
            line_end  <= 1'b0;
            if (accept) begin
                unique case (phase)
                    PH0: b0 <= byte_data;
                    PH1: b1 <= byte_data;
                    PH2: b2 <= byte_data;
                    PH3: ;
                endcase
            end
            if (vsync) begin
                cnt  <= '0;
                pend <= 1'b0;
            end else begin
                if (pend || (group_done && room)) begin
                    yuv_valid <= 1'b1;
                    yuv_data  <= pend ? pend_data : {y0, u, v};
                    pixel_col <= cnt[CW-1:0];
                    line_end  <= (cnt == LW - 1'b1);
                    // A line closing under a pending pixel clears after it.
                    cnt <= (pend && line_close) ? '0 : cnt + 1'b1;
                end else if (line_close) begin
                    cnt <= '0;
                end
                pend <= group_done && room;
                if (group_done) pend_data <= {y1, u, v};
                if (group_done && !room)
                    frag_err <= 1'b1;
                if (line_close &&
                    (phase != PH0 || cnt + (CW+1)'(pend) != LW))
                    frag_err <= 1'b1;
            end
        end
    end

`ifdef YUV422_ROW_COUNT_EN
    logic vsync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            pixel_row <= '0;
            frame_end <= 1'b0;
        end else begin
            vsync_q   <= vsync;
            frame_end <= vsync && !vsync_q && (pixel_row != '0);
            if (vsync)           pixel_row <= '0;
            else if (line_close) pixel_row <= pixel_row + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_yuv422_unpacker.sv
// Scoreboard bench for yuv422_unpacker: both byte orders driven in parallel
// against a byte-level reference model; a negedge monitor pops expectations.
module tb_yuv422_unpacker;

    localparam int LW = 4;

    typedef struct {
        logic [23:0] d;
        int          col;
        bit          le;
        int          cyc;
    } exp_t;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = '0;

    logic [23:0] yd0, yd1;
    logic        yv0, yv1, le0, le1, fe0, fe1;
    logic [1:0]  pc0, pc1;
`ifdef YUV422_ROW_COUNT_EN
    logic [9:0]  row0, row1;
    logic        fend0, fend1;
`endif

    yuv422_unpacker #(.LINE_WIDTH(LW), .BYTE_ORDER(0)) u0 (
        .clk(clk), .reset(reset), .vsync(vsync), .href(href),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .yuv_data(yd0), .yuv_valid(yv0), .pixel_col(pc0),
        .line_end(le0), .frag_err(fe0)
`ifdef YUV422_ROW_COUNT_EN
        , .pixel_row(row0), .frame_end(fend0)
`endif
    );

    yuv422_unpacker #(.LINE_WIDTH(LW), .BYTE_ORDER(1)) u1 (
        .clk(clk), .reset(reset), .vsync(vsync), .href(href),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .yuv_data(yd1), .yuv_valid(yv1), .pixel_col(pc1),
        .line_end(le1), .frag_err(fe1)
`ifdef YUV422_ROW_COUNT_EN
        , .pixel_row(row1), .frame_end(fend1)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   started = 0;
    exp_t q0[$];
    exp_t q1[$];

    // reference model state
    logic [7:0] grp[$];
    int         m_cnt = 0;
    bit         m_frag = 0;
    bit         m_href_prev = 0;
    bit         m_vs_prev = 0;
    int         m_row = 0;
    bit         m_fe = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic purge(input int n);
        while (q0.size() > 0 && q0[$].cyc >= n) void'(q0.pop_back());
        while (q1.size() > 0 && q1[$].cyc >= n) void'(q1.pop_back());
    endtask

    // Effect of the inputs on clock edge number n.
    task automatic model(input bit rs, input bit vs, input bit hr,
                         input bit bv, input logic [7:0] bd, input int n);
        bit close;
        logic [7:0] y0, y1, u, v;
        exp_t e0, e1;
        close = !rs && !vs && m_href_prev && !hr;
        if (rs) begin
            grp.delete();
            m_cnt = 0;
            m_frag = 0;
            m_href_prev = 0;
            m_vs_prev = 0;
            m_row = 0;
            m_fe = 0;
            purge(n);
            return;
        end
        m_fe = vs && !m_vs_prev && (m_row != 0);
        m_vs_prev = vs;
        if (vs) begin
            grp.delete();
            m_cnt = 0;
            m_row = 0;
            m_href_prev = hr;
            purge(n);
            return;
        end
        if (bv && hr) begin
            grp.push_back(bd);
            if (grp.size() == 4) begin
                if (m_cnt < LW) begin
                    for (int o = 0; o < 2; o++) begin
                        y0 = (o == 1) ? grp[1] : grp[0];
                        u  = (o == 1) ? grp[0] : grp[1];
                        y1 = (o == 1) ? grp[3] : grp[2];
                        v  = (o == 1) ? grp[2] : grp[3];
                        e0 = '{d: {y0, u, v}, col: m_cnt,
                               le: (m_cnt == LW - 1), cyc: n};
                        e1 = '{d: {y1, u, v}, col: m_cnt + 1,
                               le: (m_cnt + 1 == LW - 1), cyc: n + 1};
                        if (o == 0) begin
                            q0.push_back(e0);
                            q0.push_back(e1);
                        end else begin
                            q1.push_back(e0);
                            q1.push_back(e1);
                        end
                    end
                    m_cnt += 2;
                end else begin
                    m_frag = 1;
                end
                grp.delete();
            end
        end
        if (close) begin
            if (grp.size() != 0) m_frag = 1;
            grp.delete();
            if (m_cnt != LW) m_frag = 1;
            m_cnt = 0;
            m_row = (m_row + 1) % 1024;
        end
        m_href_prev = hr;
    endtask

    task automatic step(input bit rs, input bit vs, input bit hr,
                        input bit bv, input logic [7:0] bd);
        reset = rs;
        vsync = vs;
        href = hr;
        byte_valid = bv;
        byte_data = bd;
        model(rs, vs, hr, bv, bd, cyc + 1);
        @(posedge clk);
        #1;
        chk("frag_err_bo0", fe0, m_frag);
        chk("frag_err_bo1", fe1, m_frag);
`ifdef YUV422_ROW_COUNT_EN
        chk("pixel_row", row0, m_row);
        chk("frame_end", fend0, m_fe);
`endif
    endtask

    task automatic idle(input int k);
        repeat (k) step(0, 0, 0, 0, 8'h00);
    endtask

    task automatic send_bytes(input bq_t b, input bit toggle);
        foreach (b[i]) begin
            step(0, 0, 1, 1, b[i]);
            if (toggle) step(0, 0, 1, 0, 8'($urandom_range(255)));
        end
        idle(4);
    endtask

    task automatic rand_line(input int nbytes, input int gap_pct,
                             input int vs_pct);
        int sent = 0;
        int guard = 0;
        bit bv, vs;
        while (sent < nbytes && guard < 200) begin
            bv = ($urandom_range(99) >= gap_pct);
            vs = ($urandom_range(99) < vs_pct);
            step(0, vs, 1, bv, 8'($urandom_range(255)));
            if (bv && !vs) sent++;
            guard++;
        end
        idle(4);
    endtask

    task automatic mon(input int id, input logic v, input logic [23:0] d,
                       input logic [1:0] c, input logic le);
        exp_t e;
        bit have = 0;
        if (id == 0 && q0.size() > 0) begin e = q0[0]; have = 1; end
        if (id == 1 && q1.size() > 0) begin e = q1[0]; have = 1; end
        n_chk++;
        if (v === 1'b1) begin
            if (!have) begin
                n_fail++;
                $display("FAIL unexpected_pixel bo%0d: got %h col %0d cyc %0d",
                         id, d, c, cyc);
            end else begin
                if (id == 0) void'(q0.pop_front());
                else         void'(q1.pop_front());
                if (d !== e.d || int'(c) != e.col || le !== e.le ||
                    cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL pixel bo%0d: got %h col %0d le %b cyc %0d expected %h col %0d le %b cyc %0d",
                             id, d, c, le, cyc, e.d, e.col, e.le, e.cyc);
                end
            end
        end else if (v !== 1'b0 || le !== 1'b0 || (have && e.cyc <= cyc)) begin
            n_fail++;
            $display("FAIL idle bo%0d: got valid %b line_end %b at cyc %0d expected pixel %h due cyc %0d",
                     id, v, le, cyc, have ? e.d : 24'h0, have ? e.cyc : -1);
            if (have && e.cyc <= cyc) begin
                if (id == 0) void'(q0.pop_front());
                else         void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            mon(0, yv0, yd0, pc0, le0);
            mon(1, yv1, yd1, pc1, le1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int lens[8] = '{8, 8, 8, 8, 6, 12, 4, 10};

    initial begin
        bq_t b;
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        started = 1;
        chk("rst_yuv_data", yd0, 0);
        chk("rst_yuv_valid", yv0, 0);
        chk("rst_pixel_col", pc0, 0);
        chk("rst_line_end", le0, 0);
        idle(2);

        b = '{8'h10, 8'h80, 8'h20, 8'h90, 8'h30, 8'h70, 8'h40, 8'h60};
        send_bytes(b, 0);

        b = '{8'h80, 8'h10, 8'h90, 8'h20, 8'h55, 8'h66, 8'h77, 8'h88};
        send_bytes(b, 1);

        // short line, then a good line while frag_err stays set
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_bytes(b, 0);
        chk("short_line_frag", fe0, 1);
        b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        send_bytes(b, 0);

        // overrun: three groups into a four-pixel line
        step(1, 0, 0, 0, 8'h00);
        idle(1);
        b = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
              8'h27, 8'h28, 8'h29, 8'h2a, 8'h2b, 8'h2c};
        send_bytes(b, 0);
        chk("overrun_frag", fe0, 1);

        // reset after the PH2 byte
        step(1, 0, 0, 0, 8'h00);
        idle(1);
        step(0, 0, 1, 1, 8'h31);
        step(0, 0, 1, 1, 8'h32);
        step(0, 0, 1, 1, 8'h33);
        step(1, 0, 0, 0, 8'h00);
        chk("midreset_yuv_data", yd0, 0);
        chk("midreset_yuv_valid", yv0, 0);
        chk("midreset_pixel_col", pc0, 0);
        chk("midreset_frag", fe0, 0);
        idle(1);
        b = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
        send_bytes(b, 0);

        // vsync pulse mid-group with href held high
        step(0, 0, 1, 1, 8'h51);
        step(0, 0, 1, 1, 8'h52);
        step(0, 1, 1, 0, 8'h00);
        step(0, 1, 1, 1, 8'h53);
        b = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
        send_bytes(b, 0);
        chk("vsync_no_frag", fe0, 0);

        // vsync right after a group completes drops the pending pixel
        step(0, 0, 1, 1, 8'h71);
        step(0, 0, 1, 1, 8'h72);
        step(0, 0, 1, 1, 8'h73);
        step(0, 0, 1, 1, 8'h74);
        step(0, 1, 1, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        idle(3);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7) == 0) step(1, 0, 0, 0, 8'h00);
            if ($urandom_range(9) == 0) begin
                step(0, 1, 0, 0, 8'h00);
                step(0, 1, 0, 0, 8'h00);
            end
            rand_line(lens[$urandom_range(7)], 30, 2);
        end

        idle(6);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
